peripheral_msi_wb_resize_seq: RTL and testbench

PERIPHERAL_MSI_WB_RESIZE_SEQ -- requirements
Module: peripheral_msi_wb_resize_seq

---
 rtl/peripheral_msi_wb_resize_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_peripheral_msi_wb_resize_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_wb_resize_seq.sv
// Wishbone width adapter: turns one 32-bit classic master access into a
// sequence of 8-bit classic slave accesses, one per selected byte lane,
// walking the lanes from sel[3] (byte offset 0) down to sel[0] (offset 3).
module peripheral_msi_wb_resize_seq #(
  parameter int AW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // master side (32-bit)
  input  logic [AW-1:0] wbm_adr_i,
  input  logic [31:0]   wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  output logic [31:0]   wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,
  // slave side (8-bit)
  output logic [AW-1:0] wbs_adr_o,
  output logic [7:0]    wbs_dat_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [7:0]    wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-3:0] adr_q, adr_d;      // latched word address
  logic [31:0]   dat_q, dat_d;      // latched write data
  logic [3:0]    pend_q, pend_d;    // lanes still to be transferred
  logic          we_q, we_d;
  logic [7:0]    rbuf_q [4];        // read bytes, index = byte offset
  logic [7:0]    rbuf_d [4];

  logic [AW-1:0] wbs_adr_q, wbs_adr_d;
  logic [7:0]    wbs_dat_q, wbs_dat_d;
  logic          wbs_we_q, wbs_we_d;
  logic          wbs_cyc_q, wbs_cyc_d;
  logic          wbs_stb_q, wbs_stb_d;
  logic [31:0]   wbm_dat_q, wbm_dat_d;
  logic          wbm_ack_q, wbm_ack_d;
  logic          wbm_err_q, wbm_err_d;
  logic          wbm_rty_q, wbm_rty_d;

  logic [1:0]    cur_lane, nxt_lane, first_sel_lane;
  logic [3:0]    pend_after;
  logic [31:0]   cap_word;          // read buffer including the byte arriving now

  // Address bits [1:0] carry no meaning on the word-addressed master port.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbm_adr_i[1:0];

  // Byte offset of the highest-priority pending lane (sel[3] first).
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[3])      return 2'd0;
    else if (m[2]) return 2'd1;
    else if (m[1]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Mask bit of the lane at a given byte offset.
  function automatic logic [3:0] lane_bit(input logic [1:0] l);
    case (l)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Byte of a big-endian word at a given byte offset.
  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  assign cur_lane       = first_lane(pend_q);
  assign pend_after     = pend_q & ~lane_bit(cur_lane);
  assign nxt_lane       = first_lane(pend_after);
  assign first_sel_lane = first_lane(wbm_sel_i);

  // Assemble the returned word, substituting the byte being acked this cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign cap_word[31-8*gi -: 8] = (cur_lane == 2'(gi)) ? wbs_dat_i : rbuf_q[gi];
  end

  // Next-state and registered-output logic for the lane sequencer.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    pend_d    = pend_q;
    we_d      = we_q;
    for (int i = 0; i < 4; i++) rbuf_d[i] = rbuf_q[i];
    wbs_adr_d = wbs_adr_q;
    wbs_dat_d = wbs_dat_q;
    wbs_we_d  = wbs_we_q;
    wbs_cyc_d = wbs_cyc_q;
    wbs_stb_d = wbs_stb_q;
    wbm_dat_d = '0;
    wbm_ack_d = 1'b0;
    wbm_err_d = 1'b0;
    wbm_rty_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (wbm_sel_i != 4'b0000) begin
            adr_d     = wbm_adr_i[AW-1:2];
            dat_d     = wbm_dat_i;
            pend_d    = wbm_sel_i;
            we_d      = wbm_we_i;
            for (int i = 0; i < 4; i++) rbuf_d[i] = '0;
            wbs_cyc_d = 1'b1;
            wbs_stb_d = 1'b1;
            wbs_we_d  = wbm_we_i;
            wbs_adr_d = {wbm_adr_i[AW-1:2], first_sel_lane};
            wbs_dat_d = lane_byte(wbm_dat_i, first_sel_lane);
            state_d   = XFER;
          end else begin
            // Nothing selected: acknowledge with an all-zero word.
            wbm_ack_d = 1'b1;
            state_d   = RESP;
          end
        end
      end

      XFER: begin
        if (!wbm_cyc_i || wbs_err_i || wbs_rty_i ||
            (wbs_ack_i && pend_after == 4'b0000)) begin
          // Any way out of the transfer releases the slave bus.
          wbs_cyc_d = 1'b0;
          wbs_stb_d = 1'b0;
          wbs_we_d  = 1'b0;
          wbs_adr_d = '0;
          wbs_dat_d = '0;
          pend_d    = '0;
        end
        if (!wbm_cyc_i) begin
          // Master abandoned the cycle: quietly discard everything.
          state_d = IDLE;
        end else if (wbs_err_i) begin
          wbm_err_d = 1'b1;
          state_d   = RESP;
        end else if (wbs_rty_i) begin
          wbm_rty_d = 1'b1;
          state_d   = RESP;
        end else if (wbs_ack_i) begin
          rbuf_d[cur_lane] = wbs_dat_i;
          if (pend_after != 4'b0000) begin
            pend_d    = pend_after;
            wbs_adr_d = {adr_q, nxt_lane};
            wbs_dat_d = lane_byte(dat_q, nxt_lane);
          end else begin
            wbm_ack_d = 1'b1;
            wbm_dat_d = we_q ? 32'h0 : cap_word;
            state_d   = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the slave bus at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      pend_q    <= '0;
      we_q      <= 1'b0;
      for (int i = 0; i < 4; i++) rbuf_q[i] <= '0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_cyc_q <= 1'b0;
      wbs_stb_q <= 1'b0;
      wbm_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      pend_q    <= pend_d;
      we_q      <= we_d;
      for (int i = 0; i < 4; i++) rbuf_q[i] <= rbuf_d[i];
      wbs_adr_q <= wbs_adr_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_we_q  <= wbs_we_d;
      wbs_cyc_q <= wbs_cyc_d;
      wbs_stb_q <= wbs_stb_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_ack_q <= wbm_ack_d;
      wbm_err_q <= wbm_err_d;
      wbm_rty_q <= wbm_rty_d;
    end
  end

  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_cyc_o = wbs_cyc_q;
  assign wbs_stb_o = wbs_stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;
  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_rty_o = wbm_rty_q;

endmodule

// File: tb/tb_peripheral_msi_wb_resize_seq.sv
// Bench for the 32-to-8 bit Wishbone resizer: a master driver, a byte-wide
// memory slave with programmable wait states / err / rty, and scoreboards
// for the expected slave accesses and master terminations.
module tb_peripheral_msi_wb_resize_seq;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wbm_adr_i;
  logic [31:0]   wbm_dat_i;
  logic [3:0]    wbm_sel_i;
  logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [31:0]   wbm_dat_o;
  logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [7:0]    wbs_dat_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [7:0]    wbs_dat_i;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;

  peripheral_msi_wb_resize_seq #(.AW(AW)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] adr; logic we; logic [7:0] dat;} sacc_t;
  typedef struct {logic [2:0] term; logic [31:0] dat;} mresp_t;

  sacc_t  sexp_q[$];
  mresp_t mexp_q[$];
  logic [7:0] mem [1024];
  int n_cmp = 0;
  int n_bad = 0;
  int waits = 0;
  int slv_n = 0;
  int err_at = -1;
  int rty_at = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-wide memory slave; answers on the falling edge so the DUT samples
  // ack/err/rty and read data on the following rising edge.
  initial begin
    int cnt;
    sacc_t e;
    cnt = 0;
    wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0; wbs_dat_i = '0;
    forever begin
      @(negedge clk);
      wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0; wbs_dat_i = '0;
      if (rst || !(wbs_cyc_o && wbs_stb_o)) begin
        cnt = 0;
      end else if (cnt < waits) begin
        cnt++;
      end else begin
        cnt = 0;
        if (sexp_q.size() == 0) begin
          chk("slv_unexpected", wbs_adr_o, 32'hFFFF_FFFF);
        end else begin
          e = sexp_q.pop_front();
          chk("slv_adr", wbs_adr_o, e.adr);
          chk("slv_we", 32'(wbs_we_o), 32'(e.we));
          if (e.we) chk("slv_wdat", 32'(wbs_dat_o), 32'(e.dat));
        end
        wbs_dat_i = mem[wbs_adr_o[9:0]];
        if (slv_n == err_at)      wbs_err_i = 1;
        else if (slv_n == rty_at) wbs_rty_i = 1;
        else begin
          wbs_ack_i = 1;
          if (wbs_we_o) mem[wbs_adr_o[9:0]] = wbs_dat_o;
        end
        slv_n++;
      end
      $display("slave  #%0d adr=%h we=%0d wdat=%h rdat=%h ack=%0d err=%0d rty=%0d",
               slv_n, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i);
    end
  end

  // Continuous master-side rules: at most one termination, data zero unless ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("term_onehot", 32'($countones({wbm_ack_o, wbm_err_o, wbm_rty_o}) <= 1), 32'd1);
        if (!wbm_ack_o) chk("dat_idle_zero", wbm_dat_o, 32'h0);
      end
    end
  end

  // One master access; nsl = number of slave accesses expected, lat < 0 skips timing.
  task automatic mreq(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic [2:0] term, input int nsl, input int lat);
    mresp_t m, r;
    sacc_t s;
    int pushed, cyc_cnt;
    logic [31:0] rd;
    pushed = 0;
    rd = '0;
    for (int k = 0; k < 4; k++) begin
      if (sel[3-k]) begin
        rd[31-8*k -: 8] = mem[(adr[9:0] & 10'h3FC) + 10'(k)];
        if (pushed < nsl) begin
          s.adr = {adr[31:2], 2'(k)};
          s.we  = we;
          s.dat = dat[31-8*k -: 8];
          sexp_q.push_back(s);
          pushed++;
        end
      end
    end
    m.term = term;
    m.dat  = (term == 3'b100 && !we) ? rd : 32'h0;
    mexp_q.push_back(m);
    @(posedge clk); #1;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1; wbm_stb_i = 1;
    cyc_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc_cnt++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) break;
    end
    r = mexp_q.pop_front();
    chk("m_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'(r.term));
    chk("m_dat", wbm_dat_o, r.dat);
    if (lat >= 0) chk("m_latency", 32'(cyc_cnt), 32'(lat));
    $display("master adr=%h sel=%b we=%0d wdat=%h -> term=%b rdat=%h cycles=%0d",
             adr, sel, we, dat, {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, cyc_cnt);
    wbm_cyc_i = 0; wbm_stb_i = 0;
    @(posedge clk); #1;
    chk("term_one_cycle", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'h0);
    chk("slv_all_seen", 32'(sexp_q.size()), 32'h0);
    sexp_q.delete();
    err_at = -1; rty_at = -1;
  endtask

  initial begin
    int base;
    logic [3:0] rsel;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    rst = 1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 0; wbm_cyc_i = 0; wbm_stb_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wbs_cyc_o), 0);
    chk("rst_stb", 32'(wbs_stb_o), 0);
    chk("rst_we", 32'(wbs_we_o), 0);
    chk("rst_adr", wbs_adr_o, 0);
    chk("rst_sdat", 32'(wbs_dat_o), 0);
    chk("rst_mdat", wbm_dat_o, 0);
    chk("rst_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 0);
    chk("cti_bte", 32'({wbs_cti_o, wbs_bte_o}), 0);
    rst = 0;

    // Full-word write with a zero-wait slave, then read it back.
    waits = 0;
    mreq(32'h100, 32'hAABBCCDD, 4'b1111, 1, 3'b100, 4, 5);
    chk("mem_100", {mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}, 32'hAABBCCDD);
    mreq(32'h100, 32'h0, 4'b1111, 0, 3'b100, 4, 5);

    // Sparse read with two wait states per byte.
    mem[10'h101] = 8'h11; mem[10'h103] = 8'h22;
    waits = 2;
    mreq(32'h100, 32'h0, 4'b0101, 0, 3'b100, 2, -1);
    waits = 0;
    mreq(32'h104, 32'h0, 4'b0010, 0, 3'b100, 1, 2);

    // Error on the second byte: later bytes are never issued.
    err_at = slv_n + 1;
    mreq(32'h108, 32'h0, 4'b1111, 0, 3'b010, 2, 3);
    // Retry on the first byte.
    rty_at = slv_n;
    mreq(32'h10C, 32'h12345678, 4'b1100, 1, 3'b001, 1, 2);

    // Empty select: immediate ack, no slave traffic.
    base = slv_n;
    mreq(32'h110, 32'hDEADBEEF, 4'b0000, 1, 3'b100, 0, 1);
    chk("sel0_no_slave", 32'(slv_n), 32'(base));

    // Master drops cyc after the first byte is acked.
    begin
      sacc_t s;
      s.we = 0; s.dat = '0;
      s.adr = 32'h200; sexp_q.push_back(s);
      s.adr = 32'h201; sexp_q.push_back(s);
      @(posedge clk); #1;
      wbm_adr_i = 32'h200; wbm_sel_i = 4'b1111; wbm_we_i = 0; wbm_cyc_i = 1; wbm_stb_i = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wbm_cyc_i = 0; wbm_stb_i = 0;
      @(posedge clk); #1;
      chk("abort_cyc_low", 32'({wbs_cyc_o, wbs_stb_o}), 0);
      for (int i = 0; i < 3; i++) begin
        chk("abort_no_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 0);
        @(posedge clk); #1;
      end
      chk("abort_slv_seen", 32'(sexp_q.size()), 0);
      sexp_q.delete();
      $display("master abort after first byte, wbs_cyc_o=%0d", wbs_cyc_o);
    end
    mreq(32'h204, 32'hCAFEF00D, 4'b1111, 1, 3'b100, 4, 5);

    // Reset asserted between clock edges in the middle of a transfer.
    waits = 3;
    @(posedge clk); #1;
    wbm_adr_i = 32'h300; wbm_sel_i = 4'b1111; wbm_we_i = 0; wbm_cyc_i = 1; wbm_stb_i = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_stb", 32'(wbs_stb_o), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_stb", 32'({wbs_cyc_o, wbs_stb_o}), 0);
    chk("async_rst_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 0);
    wbm_cyc_i = 0; wbm_stb_i = 0;
    $display("reset mid-transfer, wbs_stb_o=%0d", wbs_stb_o);
    @(posedge clk); #1;
    rst = 0;
    waits = 0;
    mreq(32'h300, 32'h0, 4'b1001, 0, 3'b100, 2, 3);

    // Random mix of reads and writes with varying slave speed.
    for (int i = 0; i < 8; i++) begin
      rsel  = 4'($urandom);
      waits = $urandom_range(0, 2);
      mreq(32'h340 + 32'(4 * (i % 4)), $urandom, rsel, i < 4, 3'b100, 4,
           waits == 0 ? $countones(rsel) + 1 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
